// File: rtl/ghost_mover_pkg.sv
// Shared definitions for the maze movers: direction codes, grid defaults and
// the mover FSM state type.
package ghost_mover_pkg;

    localparam int GRID_W     = 20;
    localparam int GRID_H     = 15;
    localparam int TUNNEL_ROW = 7;

    localparam logic [2:0] DIR_STOP  = 3'd0;
    localparam logic [2:0] DIR_RIGHT = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_UP    = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUERY = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mover_state_t;

endpackage

// File: rtl/ghost_next_cell.sv
// Combinational candidate-cell calculation for one grid step, including the
// tunnel-row horizontal wrap and off-grid detection.
module ghost_next_cell
    import ghost_mover_pkg::*;
#(
    parameter int GRID_W     = ghost_mover_pkg::GRID_W,
    parameter int GRID_H     = ghost_mover_pkg::GRID_H,
    parameter int X_W        = 5,
    parameter int Y_W        = 4,
    parameter int TUNNEL_ROW = ghost_mover_pkg::TUNNEL_ROW
) (
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    input  logic [2:0]     dir,
    output logic [X_W-1:0] cand_x,
    output logic [Y_W-1:0] cand_y,
    output logic           is_move,
    output logic           off_grid
);

    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);
    localparam logic [Y_W-1:0] Y_TUN = Y_W'(TUNNEL_ROW);

    logic on_tunnel;
    assign on_tunnel = (cur_y == Y_TUN);

    always_comb begin
        cand_x   = cur_x;
        cand_y   = cur_y;
        is_move  = 1'b1;
        off_grid = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                if (cur_x == X_MAX) begin
                    if (on_tunnel) cand_x = '0;
                    else           off_grid = 1'b1;
                end else begin
                    cand_x = cur_x + X_W'(1);
                end
            end
            DIR_LEFT: begin
                if (cur_x == '0) begin
                    if (on_tunnel) cand_x = X_MAX;
                    else           off_grid = 1'b1;
                end else begin
                    cand_x = cur_x - X_W'(1);
                end
            end
            DIR_UP: begin
                if (cur_y == '0) off_grid = 1'b1;
                else             cand_y = cur_y - Y_W'(1);
            end
            DIR_DOWN: begin
                if (cur_y == Y_MAX) off_grid = 1'b1;
                else                cand_y = cur_y + Y_W'(1);
            end
            default: is_move = 1'b0;
        endcase
    end

endmodule

// File: rtl/ghost_mover.sv
// Ghost position owner: on each movement tick, checks the candidate cell
// against the wall map and commits or refuses the step.
module ghost_mover
    import ghost_mover_pkg::*;
#(
    parameter int GRID_W     = ghost_mover_pkg::GRID_W,
    parameter int GRID_H     = ghost_mover_pkg::GRID_H,
    parameter int X_W        = 5,
    parameter int Y_W        = 4,
    parameter int START_X    = 9,
    parameter int START_Y    = 7,
    parameter int TUNNEL_ROW = ghost_mover_pkg::TUNNEL_ROW
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [2:0]     GhostDirection,
    input  logic           move_tick,
    output logic           map_rd,
    output logic [X_W-1:0] map_x,
    output logic [Y_W-1:0] map_y,
    input  logic           map_wall,
    output logic [X_W-1:0] ghost_x,
    output logic [Y_W-1:0] ghost_y,
    output logic [2:0]     ghost_dir,
    output logic           busy,
    output logic           step_done,
    output logic           step_blocked,
    output logic           overrun,
    output mover_state_t   dbg_state
);

    mover_state_t   state_q, state_d;
    logic [X_W-1:0] x_q, x_d, cand_x_q, cand_x_d;
    logic [Y_W-1:0] y_q, y_d, cand_y_q, cand_y_d;
    logic [2:0]     dir_q, dir_d, face_q, face_d;
    logic           map_rd_q, map_rd_d;
    logic           done_q, done_d;
    logic           blocked_q, blocked_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;

    logic [X_W-1:0] nc_x;
    logic [Y_W-1:0] nc_y;
    logic           nc_move, nc_off;

    ghost_next_cell #(
        .GRID_W     (GRID_W),
        .GRID_H     (GRID_H),
        .X_W        (X_W),
        .Y_W        (Y_W),
        .TUNNEL_ROW (TUNNEL_ROW)
    ) u_next_cell (
        .cur_x    (x_q),
        .cur_y    (y_q),
        .dir      (GhostDirection),
        .cand_x   (nc_x),
        .cand_y   (nc_y),
        .is_move  (nc_move),
        .off_grid (nc_off)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        dir_d     = dir_q;
        face_d    = face_q;
        map_rd_d  = 1'b0;
        done_d    = 1'b0;
        blocked_d = 1'b0;
        // A tick that lands while any step is in flight is lost for good.
        overrun_d = overrun_q | (move_tick && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (move_tick) begin
                    dir_d = GhostDirection;
                    if (!nc_move || nc_off) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        blocked_d = nc_move;
                    end else begin
                        state_d  = ST_QUERY;
                        map_rd_d = 1'b1;
                        cand_x_d = nc_x;
                        cand_y_d = nc_y;
                    end
                end
            end
            ST_QUERY: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                if (map_wall) begin
                    blocked_d = 1'b1;
                end else begin
                    x_d    = cand_x_q;
                    y_d    = cand_y_q;
                    face_d = dir_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            x_q       <= X_W'(START_X);
            y_q       <= Y_W'(START_Y);
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            dir_q     <= DIR_STOP;
            face_q    <= DIR_RIGHT;
            map_rd_q  <= 1'b0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            dir_q     <= dir_d;
            face_q    <= face_d;
            map_rd_q  <= map_rd_d;
            done_q    <= done_d;
            blocked_q <= blocked_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign map_rd       = map_rd_q;
    assign map_x        = cand_x_q;
    assign map_y        = cand_y_q;
    assign ghost_x      = x_q;
    assign ghost_y      = y_q;
    assign ghost_dir    = face_q;
    assign busy         = busy_q;
    assign step_done    = done_q;
    assign step_blocked = blocked_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: directed scenarios plus randomized steps against a
// grid-level reference model with a wall-map responder.
module tb_ghost_mover;
    import ghost_mover_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   GhostDirection = 3'd0;
    logic         move_tick = 1'b0;
    logic         map_rd;
    logic [4:0]   map_x;
    logic [3:0]   map_y;
    logic         map_wall = 1'b0;
    logic [4:0]   ghost_x;
    logic [3:0]   ghost_y;
    logic [2:0]   ghost_dir;
    logic         busy, step_done, step_blocked, overrun;
    mover_state_t dbg_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // reference model state
    int mx, my, mdir;
    bit wall_mem [0:14][0:19];

    ghost_mover dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .GhostDirection (GhostDirection),
        .move_tick      (move_tick),
        .map_rd         (map_rd),
        .map_x          (map_x),
        .map_y          (map_y),
        .map_wall       (map_wall),
        .ghost_x        (ghost_x),
        .ghost_y        (ghost_y),
        .ghost_dir      (ghost_dir),
        .busy           (busy),
        .step_done      (step_done),
        .step_blocked   (step_blocked),
        .overrun        (overrun),
        .dbg_state      (dbg_state)
    );

    // clock and reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // wall-map responder: data valid in the cycle after map_rd, junk otherwise
    bit         rd_seen = 1'b0;
    logic [4:0] rd_x;
    logic [3:0] rd_y;
    always @(negedge clk) begin
        rd_seen = map_rd;
        rd_x    = map_x;
        rd_y    = map_y;
    end
    always @(posedge clk) begin
        #1;
        if (rd_seen && rd_x < 5'd20 && rd_y < 4'd15) map_wall = wall_mem[rd_y][rd_x];
        else                                        map_wall = 1'($urandom);
    end

    task automatic clear_walls();
        for (int yy = 0; yy < 15; yy++)
            for (int xx = 0; xx < 20; xx++)
                wall_mem[yy][xx] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        move_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mx = 9; my = 7; mdir = 1;
    endtask

    // one tick, monitored until step_done, checked against the grid model
    task automatic run_step(input logic [2:0] d);
        int nx, ny, done_c, rd_c, rd_count;
        bit mv, exp_q, exp_b, blk_seen, busy_ok;
        logic [4:0] rdx;
        logic [3:0] rdy;
        nx = mx; ny = my; mv = 1'b1; exp_q = 1'b0; exp_b = 1'b0;
        case (d)
            3'd1: nx = mx + 1;
            3'd2: nx = mx - 1;
            3'd3: ny = my - 1;
            3'd4: ny = my + 1;
            default: mv = 1'b0;
        endcase
        if (mv) begin
            if ((nx < 0 || nx >= 20) && my == 7) nx = (nx + 20) % 20;
            if (nx < 0 || nx >= 20 || ny < 0 || ny >= 15) begin
                exp_b = 1'b1;
            end else begin
                exp_q = 1'b1;
                exp_b = wall_mem[ny][nx];
                if (!exp_b) begin
                    mx = nx; my = ny; mdir = int'(d);
                end
            end
        end

        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_idle got %0b want 0", busy);
        else pass_cnt++;
        GhostDirection = d;
        move_tick = 1'b1;
        @(posedge clk);
        #1;
        move_tick = 1'b0;
        GhostDirection = 3'($urandom);

        done_c = 0; rd_c = 0; rd_count = 0; blk_seen = 1'b0; busy_ok = 1'b1;
        rdx = '0; rdy = '0;
        for (int c = 1; c <= 6 && done_c == 0; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (map_rd === 1'b1) begin
                rd_count++; rd_c = c; rdx = map_x; rdy = map_y;
            end
            if (step_done === 1'b1) begin
                done_c = c; blk_seen = step_blocked;
            end
        end

        chk_cnt++;
        if (done_c !== (exp_q ? 3 : 1))
            $display("FAIL done_latency dir=%0d got %0d want %0d", d, done_c, exp_q ? 3 : 1);
        else pass_cnt++;
        chk_cnt++;
        if (rd_count !== (exp_q ? 1 : 0))
            $display("FAIL map_rd_count dir=%0d got %0d want %0d", d, rd_count, exp_q ? 1 : 0);
        else pass_cnt++;
        if (exp_q && rd_count == 1) begin
            chk_cnt++;
            if (rd_c !== 1 || rdx !== 5'(nx) || rdy !== 4'(ny))
                $display("FAIL map_query cyc=%0d got (%0d,%0d) want cyc 1 (%0d,%0d)", rd_c, rdx, rdy, nx, ny);
            else pass_cnt++;
        end
        chk_cnt++;
        if (blk_seen !== exp_b) $display("FAIL step_blocked dir=%0d got %0b want %0b", d, blk_seen, exp_b);
        else pass_cnt++;
        chk_cnt++;
        if (ghost_x !== 5'(mx) || ghost_y !== 4'(my))
            $display("FAIL ghost_pos dir=%0d got (%0d,%0d) want (%0d,%0d)", d, ghost_x, ghost_y, mx, my);
        else pass_cnt++;
        chk_cnt++;
        if (ghost_dir !== 3'(mdir)) $display("FAIL ghost_dir got %0d want %0d", ghost_dir, mdir);
        else pass_cnt++;
        chk_cnt++;
        if (!busy_ok) $display("FAIL busy_active got 0 want 1 through step");
        else pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if (ghost_x !== 5'd9) $display("FAIL reset_x got %0d want 9", ghost_x); else pass_cnt++;
        chk_cnt++; if (ghost_y !== 4'd7) $display("FAIL reset_y got %0d want 7", ghost_y); else pass_cnt++;
        chk_cnt++; if (ghost_dir !== 3'd1) $display("FAIL reset_dir got %0d want 1", ghost_dir); else pass_cnt++;
        chk_cnt++; if (map_rd !== 1'b0) $display("FAIL reset_map_rd got %0b want 0", map_rd); else pass_cnt++;
        chk_cnt++; if (map_x !== 5'd0 || map_y !== 4'd0) $display("FAIL reset_map_xy got (%0d,%0d) want (0,0)", map_x, map_y); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
        chk_cnt++; if (step_done !== 1'b0) $display("FAIL reset_done got %0b want 0", step_done); else pass_cnt++;
        chk_cnt++; if (step_blocked !== 1'b0) $display("FAIL reset_blocked got %0b want 0", step_blocked); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %0b want 0", overrun); else pass_cnt++;
        chk_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_commit_and_wall();
        do_reset();
        clear_walls();
        run_step(3'd1);
        do_reset();
        wall_mem[6][9] = 1'b1;
        run_step(3'd3);
        wall_mem[6][9] = 1'b0;
    endtask

    task automatic test_tunnel_and_edges();
        do_reset();
        clear_walls();
        for (int i = 0; i < 9; i++) run_step(3'd2);
        run_step(3'd2);
        run_step(3'd1);
        for (int i = 0; i < 4; i++) run_step(3'd3);
        run_step(3'd2);
        for (int i = 0; i < 3; i++) run_step(3'd3);
        run_step(3'd3);
        for (int i = 0; i < 14; i++) run_step(3'd4);
        run_step(3'd4);
        run_step(3'd2);
        for (int i = 0; i < 19; i++) run_step(3'd1);
        run_step(3'd1);
    endtask

    task automatic test_stationary();
        do_reset();
        run_step(3'd0);
        run_step(3'd6);
        run_step(3'd5);
        run_step(3'd7);
    endtask

    task automatic test_overrun();
        bit quiet;
        do_reset();
        clear_walls();
        @(negedge clk);
        GhostDirection = 3'd1;
        move_tick = 1'b1;
        @(posedge clk); #1;
        move_tick = 1'b0;
        @(posedge clk); #1;
        GhostDirection = 3'd2;
        move_tick = 1'b1;
        @(posedge clk); #1;
        move_tick = 1'b0;
        @(negedge clk);
        chk_cnt++; if (step_done !== 1'b1) $display("FAIL ovr_done got %0b want 1", step_done); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got %0b want 1", overrun); else pass_cnt++;
        mx = 10;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || step_done !== 1'b0) quiet = 1'b0;
        end
        chk_cnt++; if (!quiet) $display("FAIL ovr_dropped got activity want none"); else pass_cnt++;
        chk_cnt++;
        if (ghost_x !== 5'd10 || ghost_y !== 4'd7) $display("FAIL ovr_pos got (%0d,%0d) want (10,7)", ghost_x, ghost_y);
        else pass_cnt++;
        run_step(3'd4);
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %0b want 1", overrun); else pass_cnt++;
        do_reset();
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %0b want 0", overrun); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        bit quiet;
        do_reset();
        clear_walls();
        @(negedge clk);
        GhostDirection = 3'd1;
        move_tick = 1'b1;
        @(posedge clk); #1;
        move_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (ghost_x !== 5'd9 || ghost_y !== 4'd7) $display("FAIL rst_wait_pos got (%0d,%0d) want (9,7)", ghost_x, ghost_y);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0 || map_rd !== 1'b0 || step_done !== 1'b0 || step_blocked !== 1'b0)
            $display("FAIL rst_wait_flags got busy=%0b rd=%0b done=%0b blk=%0b want all 0", busy, map_rd, step_done, step_blocked);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (step_done !== 1'b0 || busy !== 1'b0 || ghost_x !== 5'd9) quiet = 1'b0;
        end
        chk_cnt++; if (!quiet) $display("FAIL rst_wait_no_commit got late activity want none"); else pass_cnt++;
        mx = 9; my = 7; mdir = 1;
    endtask

    task automatic test_random();
        do_reset();
        for (int yy = 0; yy < 15; yy++)
            for (int xx = 0; xx < 20; xx++)
                wall_mem[yy][xx] = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 80; i++) run_step(3'($urandom_range(0, 7)));
    endtask

    initial begin
        clear_walls();
        test_reset();
        test_commit_and_wall();
        test_tunnel_and_edges();
        test_stationary();
        test_overrun();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ghost_mover.md
# ghost_mover

Consumes the 3-bit ghost direction code produced by the switch-input decoder and turns it into actual ghost motion on the maze grid. On each movement tick it computes the candidate cell, queries the maze wall map through a one-cycle-latency read port, and commits or rejects the step. It sits between the direction decoder and the renderer and collision logic, owning the ghost's authoritative grid position.

## Interface
- GRID_W, 20, maze width in cells
- GRID_H, 15, maze height in cells
- X_W, 5, width of x coordinate
- Y_W, 4, width of y coordinate
- START_X, 9, x cell after reset
- START_Y, 7, y cell after reset
- TUNNEL_ROW, 7, row on which horizontal edges wrap
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- GhostDirection  in  3  0 stationary, 1 right, 2 left, 3 up, 4 down; 5–7 treated as 0
- move_tick  in  1  one-cycle step request pulse (frame-rate strobe)
- map_rd  out  1  wall-map read strobe, one cycle
- map_x  out  X_W  candidate x address, valid while map_rd=1
- map_y  out  Y_W  candidate y address, valid while map_rd=1
- map_wall  in  1  1 = wall at the addressed cell; valid exactly one cycle after map_rd
- ghost_x  out  X_W  current ghost column
- ghost_y  out  Y_W  current ghost row
- ghost_dir  out  3  last committed nonzero direction (facing, for sprite selection)
- busy  out  1  high whenever state ≠ IDLE
- step_done  out  1  one-cycle pulse ending every accepted tick
- step_blocked  out  1  one-cycle pulse coincident with step_done when a move was refused
- overrun  out  1  sticky; set when move_tick arrives while busy

## Operation
- Reset values: ghost_x=START_X, ghost_y=START_Y, ghost_dir=1, map_rd=0, map_x=0, map_y=0, busy=0, step_done=0, step_blocked=0, overrun=0, state=IDLE.
- States: IDLE, QUERY, WAIT, DONE.
- IDLE: on move_tick, sample GhostDirection into dir_q and compute candidate. Code 0 or 5–7 → DONE (no map access, blocked=0). Candidate off-grid (see below) → DONE with blocked=1, no map access. Otherwise → QUERY.
- QUERY: map_rd=1, map_x/map_y=candidate; → WAIT.
- WAIT: sample map_wall. 0 → commit candidate to ghost_x/ghost_y, ghost_dir=dir_q. 1 → position unchanged, blocked=1. → DONE.
- DONE: step_done=1, step_blocked per decision; → IDLE.
- Candidate arithmetic: right x+1, left x−1, up y−1, down y+1, in X_W/Y_W unsigned.
- Boundaries: left at x=0 on TUNNEL_ROW → candidate x=GRID_W−1; right at x=GRID_W−1 on TUNNEL_ROW → x=0; both then queried normally. Same cases off TUNNEL_ROW, and up at y=0 or down at y=GRID_H−1, are off-grid: blocked, no map_rd.
- GhostDirection changes outside IDLE are ignored; only the value at the tick edge counts.
- move_tick while busy: dropped, overrun set to 1 and held until reset.
- Blocked move does not update ghost_dir.

## Timing
- Tick sampled at edge k. Queried path: map_rd high cycle k+1, map_wall sampled cycle k+2, ghost_x/ghost_y/ghost_dir update at edge k+3, step_done high cycle k+3, IDLE at k+4; next tick accepted at edge k+4.
- Unqueried path (stationary or off-grid): DONE entered at edge k+1, step_done high cycle k+1, IDLE at k+2.
- busy high from cycle k+1 through the DONE cycle inclusive.
- A tick coincident with the DONE cycle counts as overrun.
- reset_n assertion mid-operation: immediate async return to IDLE and all reset values; any outstanding map_wall response is ignored.

## Structure
- Shared package: direction code constants (DIR_STOP=0, DIR_RIGHT=1, DIR_LEFT=2, DIR_UP=3, DIR_DOWN=4), also used by the switch and keyboard decoders; grid defaults GRID_W/GRID_H/TUNNEL_ROW.
- One sub-module is natural: ghost_next_cell (combinational candidate + off-grid/wrap calculation), reused later by the Pac-Man mover. FSM and registers stay in ghost_mover.

## Test plan
- Reset, then tick with dir=1 at (9,7), map_wall=0 → map_rd at k+1 with (10,7); ghost=(10,7), ghost_dir=1, step_done at k+3, blocked=0.
- Tick with dir=3 at (9,7), map_wall=1 → map_rd with (9,6); ghost stays (9,7), ghost_dir unchanged, step_done and step_blocked both high at k+3.
- Ghost at (0,7), dir=2, map_wall=0 → queries (19,7), ghost=(19,7); at (0,3), dir=2 → no map_rd, step_done+step_blocked at k+1.
- dir=0 and dir=6 ticks → no map_rd, position unchanged, step_done at k+1, blocked=0.
- Tick, second tick at k+2 → second ignored, overrun=1 stays set across later ticks; cleared only by reset_n.
- Assert reset_n low during WAIT with map_wall=0 → no commit; ghost=(9,7), busy=0, all pulses 0 immediately.
